sottrattore_seriale: RTL and testbench



---
 rtl/sottrattore_pkg.sv | 10 +
 rtl/sottrattore_1bit.sv | 13 +
 rtl/sottrattore_seriale.sv | 119 +++++++++++
 tb/tb_sottrattore_seriale.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sottrattore_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding.
package sottrattore_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/sottrattore_1bit.sv
// Combinational 1-bit full subtractor: d = x - y - bin, with borrow out.
module sottrattore_1bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/sottrattore_seriale.sv
// Bit-serial N-bit subtractor, LSB first, one full-subtractor cell plus a borrow flop.
// Optional signed-overflow output enabled by defining SOTTRATTORE_OVF_EN.
module sottrattore_seriale
  import sottrattore_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow
`ifdef SOTTRATTORE_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic [N-1:0]  result;
  logic [CW-1:0] cnt;
  logic          bw;
  logic          d_bit;
  logic          bout_bit;
  logic          last_bit;

`ifdef SOTTRATTORE_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  sottrattore_1bit u_cell (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (bw),
    .d    (d_bit),
    .bout (bout_bit)
  );

  assign last_bit = (cnt == LAST);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are loaded on the last RUN edge so they are already valid during the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      result <= '0;
      cnt    <= '0;
      bw     <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
`ifdef SOTTRATTORE_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            result <= '0;
            cnt    <= '0;
            bw     <= 1'b0;
`ifdef SOTTRATTORE_OVF_EN
            a_msb  <= a[N-1];
            b_msb  <= b[N-1];
`endif
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          result <= {d_bit, result[N-1:1]};
          bw     <= bout_bit;
          if (last_bit) begin
            diff   <= {d_bit, result[N-1:1]};
            borrow <= bout_bit;
`ifdef SOTTRATTORE_OVF_EN
            ovf    <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sottrattore_seriale.sv
// Directed self-checking bench for sottrattore_seriale (N=8); ovf checks under SOTTRATTORE_OVF_EN.
module tb_sottrattore_seriale;

  localparam int N = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         borrow;
`ifdef SOTTRATTORE_OVF_EN
  logic         ovf;
`endif

  int tests_run  = 0;
  int fail_count = 0;

  sottrattore_seriale #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a_in),
    .b      (b_in),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SOTTRATTORE_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Pulses start for one accepting edge, scrambles operands afterwards, and waits for done.
  task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv,
                               output int lat, output int busy_cnt,
                               output logic done_after, output logic busy_after);
    bit seen;
    seen     = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    @(negedge clk);
    a_in  = av;
    b_in  = bv;
    start = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      a_in  = ~av;
      b_in  = av;
      lat++;
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      tests_run++;
      fail_count++;
      $error("[TB] FAIL done_timeout observed=0 expected=1");
    end
    @(posedge clk);
    #1;
    done_after = done;
    busy_after = busy;
  endtask

  initial begin
    int          lat;
    int          busy_cnt;
    logic        done_after;
    logic        busy_after;
    int          dones;
    int          first_edge;
    int          second_edge;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic [N-1:0] exp_d;
    bit           drained;

    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_diff", 32'(diff), 32'd0);
    checkOutput("reset_borrow", 32'(borrow), 32'd0);
    #22;
    rst_n = 1'b1;

    // Basic latency and busy window
    applyStimulus(8'h05, 8'h03, lat, busy_cnt, done_after, busy_after);
    checkOutput("t1_latency", 32'(lat), 32'd9);
    checkOutput("t1_busy_cycles", 32'(busy_cnt), 32'd9);
    checkOutput("t1_diff", 32'(diff), 32'h02);
    checkOutput("t1_borrow", 32'(borrow), 32'd0);
    checkOutput("t1_done_width", 32'(done_after), 32'd0);
    checkOutput("t1_busy_after", 32'(busy_after), 32'd0);

    applyStimulus(8'h00, 8'h01, lat, busy_cnt, done_after, busy_after);
    checkOutput("t2a_diff", 32'(diff), 32'hFF);
    checkOutput("t2a_borrow", 32'(borrow), 32'd1);
    applyStimulus(8'hFF, 8'hFF, lat, busy_cnt, done_after, busy_after);
    checkOutput("t2b_diff", 32'(diff), 32'h00);
    checkOutput("t2b_borrow", 32'(borrow), 32'd0);

    applyStimulus(8'h80, 8'h01, lat, busy_cnt, done_after, busy_after);
    checkOutput("t3a_diff", 32'(diff), 32'h7F);
    checkOutput("t3a_borrow", 32'(borrow), 32'd0);
`ifdef SOTTRATTORE_OVF_EN
    checkOutput("t3a_ovf", 32'(ovf), 32'd1);
`endif
    applyStimulus(8'h7F, 8'hFF, lat, busy_cnt, done_after, busy_after);
    checkOutput("t3b_diff", 32'(diff), 32'h80);
    checkOutput("t3b_borrow", 32'(borrow), 32'd1);
`ifdef SOTTRATTORE_OVF_EN
    checkOutput("t3b_ovf", 32'(ovf), 32'd1);
`endif
    applyStimulus(8'h10, 8'h20, lat, busy_cnt, done_after, busy_after);
    checkOutput("t3c_diff", 32'(diff), 32'hF0);
    checkOutput("t3c_borrow", 32'(borrow), 32'd1);
`ifdef SOTTRATTORE_OVF_EN
    checkOutput("t3c_ovf", 32'(ovf), 32'd0);
`endif

    // Start held high: accepts at edges 1 and 11, done after edges 9 and 19
    dones       = 0;
    first_edge  = 0;
    second_edge = 0;
    @(negedge clk);
    a_in  = 8'h0A;
    b_in  = 8'h04;
    start = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk);
      #1;
      if (e == 3) begin
        a_in = 8'h33;
        b_in = 8'h11;
      end
      if (e == 15) checkOutput("t4_diff_hold", 32'(diff), 32'h06);
      if (done) begin
        dones++;
        if (dones == 1) begin
          first_edge = e;
          checkOutput("t4_first_diff", 32'(diff), 32'h06);
        end else if (dones == 2) begin
          second_edge = e;
          checkOutput("t4_second_diff", 32'(diff), 32'h22);
        end
      end
    end
    start = 1'b0;
    checkOutput("t4_done_count", 32'(dones), 32'd2);
    checkOutput("t4_first_edge", 32'(first_edge), 32'd9);
    checkOutput("t4_second_edge", 32'(second_edge), 32'd19);
    drained = 1'b0;
    for (int i = 0; i < 20 && !drained; i++) begin
      @(posedge clk);
      #1;
      if (done) drained = 1'b1;
    end
    checkOutput("t4_third_done", 32'(drained), 32'd1);
    checkOutput("t4_third_diff", 32'(diff), 32'h22);
    @(posedge clk);
    #1;

    // Asynchronous reset in the fourth RUN cycle
    @(negedge clk);
    a_in  = 8'h30;
    b_in  = 8'h05;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_done", 32'(done), 32'd0);
    checkOutput("t5_diff", 32'(diff), 32'd0);
    checkOutput("t5_borrow", 32'(borrow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'h09, 8'h02, lat, busy_cnt, done_after, busy_after);
    checkOutput("t5_diff_after", 32'(diff), 32'h07);
    checkOutput("t5_borrow_after", 32'(borrow), 32'd0);
    checkOutput("t5_latency", 32'(lat), 32'd9);

    // Random operand sweep
    for (int k = 0; k < 200; k++) begin
      ra    = N'($urandom_range(0, 255));
      rb    = N'($urandom_range(0, 255));
      exp_d = ra - rb;
      applyStimulus(ra, rb, lat, busy_cnt, done_after, busy_after);
      checkOutput($sformatf("rnd%0d_diff", k), 32'(diff), 32'(exp_d));
      checkOutput($sformatf("rnd%0d_borrow", k), 32'(borrow), 32'(ra < rb));
      checkOutput($sformatf("rnd%0d_done_width", k), 32'(done_after), 32'd0);
      checkOutput($sformatf("rnd%0d_latency", k), 32'(lat), 32'd9);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
